// File: rtl/pipeline_control.sv
// ============================================================================
// pipeline_control: hazard, stall, flush, redirect and forwarding control for
// the five-stage pipeline. Optional feature macro: PIPELINE_FORWARDING_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_control #(
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   i_id_rs1,
  input  logic [4:0]                   i_id_rs2,
  input  logic                         i_id_uses_rs1,
  input  logic                         i_id_uses_rs2,
  input  logic [4:0]                   i_ex_rs1,
  input  logic [4:0]                   i_ex_rs2,
  input  logic [4:0]                   i_ex_rd,
  input  logic [1:0]                   i_ex_read_status,
  input  logic                         i_ex_write_back,
  input  logic                         i_ex_mispredict,
  input  logic [31:0]                  i_ex_new_pc,
  input  logic [4:0]                   i_mem_rd,
  input  logic                         i_mem_write_back,
  input  logic                         i_mem_busy,
  input  logic [4:0]                   i_wb_rd,
  input  logic                         i_wb_write_back,
  output logic                         o_pc_enable,
  output logic                         o_if_id_enable,
  output logic                         o_id_ex_enable,
  output logic                         o_ex_mem_enable,
  output logic                         o_if_id_flush,
  output logic                         o_id_ex_flush,
  output logic                         o_redirect_valid,
  output logic [31:0]                  o_redirect_pc,
  output logic [1:0]                   o_forward_a,
  output logic [1:0]                   o_forward_b,
  output logic [STALL_COUNT_WIDTH-1:0] o_stall_count
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_REDIRECT   = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_nxt;
  logic [STALL_COUNT_WIDTH-1:0] r_stall_count;
  logic                         w_id_hit_ex;
  logic                         w_data_stall;
  logic [1:0]                   w_stall_nxt;
  logic [1:0]                   w_fwd_a;
  logic [1:0]                   w_fwd_b;

  // x0 is hardwired zero, so it can never create a dependency
  assign w_id_hit_ex = i_ex_write_back && (i_ex_rd != 5'd0) &&
                       ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                        (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

`ifdef PIPELINE_FORWARDING_EN
  function automatic logic [1:0] f_fwd_sel(input logic [4:0] rs);
    if (i_mem_write_back && (i_mem_rd != 5'd0) && (i_mem_rd == rs))
      return 2'b01;
    else if (i_wb_write_back && (i_wb_rd != 5'd0) && (i_wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign w_data_stall = w_id_hit_ex && (i_ex_read_status != 2'b00);
  assign w_stall_nxt  = ST_LOAD_STALL;
  assign w_fwd_a      = f_fwd_sel(i_ex_rs1);
  assign w_fwd_b      = f_fwd_sel(i_ex_rs2);
`else
  logic w_id_hit_mem;
  logic w_unused_fwd;

  assign w_id_hit_mem = i_mem_write_back && (i_mem_rd != 5'd0) &&
                        ((i_id_uses_rs1 && (i_id_rs1 == i_mem_rd)) ||
                         (i_id_uses_rs2 && (i_id_rs2 == i_mem_rd)));
  // Without bypass paths every in-flight producer holds decode in RUN
  assign w_data_stall = w_id_hit_ex || w_id_hit_mem;
  assign w_stall_nxt  = ST_RUN;
  assign w_fwd_a      = 2'b00;
  assign w_fwd_b      = 2'b00;
  assign w_unused_fwd = ^{i_ex_rs1, i_ex_rs2, i_ex_read_status, i_wb_rd, i_wb_write_back};
`endif

  always_comb begin
    o_pc_enable      = 1'b1;
    o_if_id_enable   = 1'b1;
    o_id_ex_enable   = 1'b1;
    o_ex_mem_enable  = 1'b1;
    o_if_id_flush    = 1'b0;
    o_id_ex_flush    = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 32'd0;
    o_forward_a      = w_fwd_a;
    o_forward_b      = w_fwd_b;
    w_state_nxt      = r_state;
    if (!rst_n) begin
      o_pc_enable     = 1'b0;
      o_if_id_enable  = 1'b0;
      o_id_ex_enable  = 1'b0;
      o_ex_mem_enable = 1'b0;
      o_if_id_flush   = 1'b1;
      o_id_ex_flush   = 1'b1;
      o_forward_a     = 2'b00;
      o_forward_b     = 2'b00;
      w_state_nxt     = ST_RUN;
    end else if (i_mem_busy) begin
      // Freeze everything; a pending mispredict stays parked in execute
      o_pc_enable     = 1'b0;
      o_if_id_enable  = 1'b0;
      o_id_ex_enable  = 1'b0;
      o_ex_mem_enable = 1'b0;
      w_state_nxt     = ST_MEM_WAIT;
    end else begin
      case (r_state)
        ST_LOAD_STALL: w_state_nxt = ST_RUN;
        ST_REDIRECT: begin
          o_if_id_flush = 1'b1;
          w_state_nxt   = ST_RUN;
        end
        default: begin
          // MEM_WAIT with memory ready behaves exactly like RUN
          w_state_nxt = ST_RUN;
          if (i_ex_mispredict) begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_ex_new_pc;
            o_if_id_flush    = 1'b1;
            o_id_ex_flush    = 1'b1;
            w_state_nxt      = ST_REDIRECT;
          end else if (w_data_stall) begin
            o_pc_enable    = 1'b0;
            o_if_id_enable = 1'b0;
            o_id_ex_flush  = 1'b1;
            w_state_nxt    = w_stall_nxt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!o_pc_enable && (r_stall_count != {STALL_COUNT_WIDTH{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control.sv
// ============================================================================
// tb_pipeline_control: scoreboard bench for pipeline_control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_control;

  localparam int SCW = 8;
`ifdef PIPELINE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [3:0] EN_ALL  = 4'b1111;
  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [3:0] EN_LU   = 4'b0011;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_write_back, ex_mispredict;
  logic        mem_write_back, mem_busy, wb_write_back;
  logic [1:0]  ex_read_status;
  logic [31:0] ex_new_pc;
  logic        pc_enable, if_id_enable, id_ex_enable, ex_mem_enable;
  logic        if_id_flush, id_ex_flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  forward_a, forward_b;
  logic [SCW-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [SCW-1:0] sc_exp = '0;
  string          tag_q[$];
  logic [50:0]    exp_q[$];

  always #5 clk = ~clk;

  pipeline_control #(.STALL_COUNT_WIDTH(SCW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
    .i_ex_read_status(ex_read_status), .i_ex_write_back(ex_write_back),
    .i_ex_mispredict(ex_mispredict), .i_ex_new_pc(ex_new_pc),
    .i_mem_rd(mem_rd), .i_mem_write_back(mem_write_back), .i_mem_busy(mem_busy),
    .i_wb_rd(wb_rd), .i_wb_write_back(wb_write_back),
    .o_pc_enable(pc_enable), .o_if_id_enable(if_id_enable),
    .o_id_ex_enable(id_ex_enable), .o_ex_mem_enable(ex_mem_enable),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_forward_a(forward_a), .o_forward_b(forward_b),
    .o_stall_count(stall_count)
  );

  task automatic check_eq(input string tag, input logic [50:0] got, input logic [50:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h  {en4,fl2,rv,pc32,fa2,fb2,sc8}", tag, got, exp);
    end
  endtask

  function automatic logic [42:0] ex(input logic [3:0] en, input logic [1:0] fl,
                                     input logic rv, input logic [31:0] pc,
                                     input logic [1:0] fa, input logic [1:0] fb);
    return {en, fl, rv, pc, fa, fb};
  endfunction

  // Called just after a negedge with inputs already driven
  task automatic run_cycle(input string tag, input logic [42:0] e);
    if (!rst_n) sc_exp = '0;
    tag_q.push_back(tag);
    exp_q.push_back({e, sc_exp});
    #2;
    check_eq(tag_q.pop_front(),
             {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, if_id_flush,
              id_ex_flush, redirect_valid, redirect_pc, forward_a, forward_b, stall_count},
             exp_q.pop_front());
    if (rst_n && !e[42] && (sc_exp != {SCW{1'b1}})) sc_exp = sc_exp + 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_read_status = 0; ex_write_back = 0;
    ex_mispredict = 0; ex_new_pc = 0;
    mem_rd = 0; mem_write_back = 0; mem_busy = 0; wb_rd = 0; wb_write_back = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    // Reset dominates even with active events on the inputs
    ex_mispredict = 1; ex_new_pc = 32'h40; mem_rd = 7; mem_write_back = 1; ex_rs1 = 7;
    run_cycle("reset_values", ex(EN_NONE, 2'b11, 0, 0, 2'b00, 2'b00));
    idle_inputs(); rst_n = 1'b1;
    run_cycle("run_idle", ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00));

    // Mispredict then REDIRECT squash
    ex_mispredict = 1; ex_new_pc = 32'h0000_0040;
    run_cycle("mispredict", ex(EN_ALL, 2'b11, 1, 32'h40, 2'b00, 2'b00));
    ex_mispredict = 0;
    run_cycle("redirect_squash", ex(EN_ALL, 2'b10, 0, 0, 2'b00, 2'b00));
    run_cycle("after_redirect", ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00));

    // Reset asserted while in REDIRECT; a hazard in the squashed slot is ignored
    ex_mispredict = 1; ex_new_pc = 32'h0000_0080;
    run_cycle("mispredict2", ex(EN_ALL, 2'b11, 1, 32'h80, 2'b00, 2'b00));
    ex_mispredict = 0;
    ex_rd = 4; ex_write_back = 1; ex_read_status = 2'b01; id_rs1 = 4; id_uses_rs1 = 1;
    run_cycle("redirect_ignores_hazard", ex(EN_ALL, 2'b10, 0, 0, 2'b00, 2'b00));
    ex_mispredict = 1;
    run_cycle("mispredict3", ex(EN_ALL, 2'b11, 1, 32'h80, 2'b00, 2'b00));
    idle_inputs();
    rst_n = 1'b0;
    run_cycle("reset_mid_redirect", ex(EN_NONE, 2'b11, 0, 0, 2'b00, 2'b00));
    rst_n = 1'b1;
    run_cycle("run_after_reset", ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00));

    // Load to x5 in EX, decode reads x5
    ex_rd = 5; ex_write_back = 1; ex_read_status = 2'b01; id_rs1 = 5; id_uses_rs1 = 1;
    run_cycle("load_use_stall", ex(EN_LU, 2'b01, 0, 0, 2'b00, 2'b00));
    ex_rd = 0; ex_write_back = 0; ex_read_status = 0; mem_rd = 5; mem_write_back = 1;
    run_cycle("load_in_mem", FWD ? ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00)
                                 : ex(EN_LU, 2'b01, 0, 0, 2'b00, 2'b00));
    idle_inputs(); wb_rd = 5; wb_write_back = 1; ex_rs1 = 5;
    run_cycle("load_in_wb_fwd", ex(EN_ALL, 2'b00, 0, 0, FWD ? 2'b10 : 2'b00, 2'b00));

    // mem_busy together with mispredict for 3 cycles
    idle_inputs(); mem_busy = 1; ex_mispredict = 1; ex_new_pc = 32'h1234_5678;
    for (int i = 0; i < 3; i++)
      run_cycle($sformatf("mem_busy_%0d", i), ex(EN_NONE, 2'b00, 0, 0, 2'b00, 2'b00));
    mem_busy = 0;
    run_cycle("held_mispredict", ex(EN_ALL, 2'b11, 1, 32'h1234_5678, 2'b00, 2'b00));
    ex_mispredict = 0;
    run_cycle("held_redirect_squash", ex(EN_ALL, 2'b10, 0, 0, 2'b00, 2'b00));

    // Forwarding priority and x0 exclusion
    idle_inputs(); mem_rd = 7; mem_write_back = 1; wb_rd = 7; wb_write_back = 1; ex_rs1 = 7;
    run_cycle("fwd_mem_wins", ex(EN_ALL, 2'b00, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00));
    wb_rd = 8; ex_rs2 = 8;
    run_cycle("fwd_a_mem_b_wb", ex(EN_ALL, 2'b00, 0, 0, FWD ? 2'b01 : 2'b00,
                                   FWD ? 2'b10 : 2'b00));
    mem_write_back = 0;
    run_cycle("fwd_no_wb_enable", ex(EN_ALL, 2'b00, 0, 0, 2'b00, FWD ? 2'b10 : 2'b00));
    idle_inputs(); mem_rd = 0; mem_write_back = 1; wb_write_back = 1;
    ex_rd = 0; ex_write_back = 1; ex_read_status = 2'b10; id_uses_rs1 = 1; id_uses_rs2 = 1;
    run_cycle("x0_no_hazard", ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00));

    // ALU producer of x3 read by decode
    idle_inputs(); ex_rd = 3; ex_write_back = 1; id_rs2 = 3; id_uses_rs2 = 1;
    run_cycle("alu_raw_ex", FWD ? ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00)
                                : ex(EN_LU, 2'b01, 0, 0, 2'b00, 2'b00));
    ex_rd = 0; ex_write_back = 0; mem_rd = 3; mem_write_back = 1;
    run_cycle("alu_raw_mem", FWD ? ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00)
                                 : ex(EN_LU, 2'b01, 0, 0, 2'b00, 2'b00));
    id_uses_rs2 = 0;
    run_cycle("unused_source", ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00));

    // Continuous stall drives the counter into saturation
    idle_inputs(); mem_busy = 1;
    for (int i = 0; i < 270; i++)
      run_cycle($sformatf("saturate_%0d", i), ex(EN_NONE, 2'b00, 0, 0, 2'b00, 2'b00));
    mem_busy = 0;
    run_cycle("saturated_hold", ex(EN_ALL, 2'b00, 0, 0, 2'b00, 2'b00));
    rst_n = 1'b0;
    run_cycle("final_reset", ex(EN_NONE, 2'b11, 0, 0, 2'b00, 2'b00));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
